controlador_memoria: RTL

Load/store initiator that drives the synchronous `datamemory` port (`rd_wr`, `endereco`, `entrada`, `saida`) on behalf of the CPU MEM stage. It accepts one byte-addressed request at a time over a valid/ready handshake. Word stores are issued directly; byte and halfword stores use read-modify-write. Loads are byte-lane extracted and optionally sign-extended, and each request completes with a one-cycle response pulse.

---
 rtl/controlador_memoria.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/controlador_memoria.sv
// Load/store initiator for the synchronous datamemory port: word stores go straight out,
// sub-word stores are read-modify-write, and loads are lane-extracted with optional sign extension.
module controlador_memoria #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_escrita,
  input  logic [1:0]        req_tam,
  input  logic              req_sinal,
  input  logic [ADDR_W+1:0] req_endereco,
  input  logic [DATA_W-1:0] req_dado,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_dado,
  output logic              resp_erro,
  output logic              mem_rd_wr,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic [DATA_W-1:0] mem_entrada,
  input  logic [DATA_W-1:0] mem_saida
);

  typedef enum logic [2:0] {IDLE, LE, CAPTURA, ESCRITA, RESP} estado_t;

  estado_t state_reg, state_next;

  logic              escrita_reg, escrita_next;
  logic [1:0]        tam_reg, tam_next;
  logic              sinal_reg, sinal_next;
  logic [1:0]        lane_reg, lane_next;
  logic [DATA_W-1:0] dado_reg, dado_next;

  logic              mem_rd_wr_next;
  logic [ADDR_W-1:0] mem_endereco_next;
  logic [DATA_W-1:0] mem_entrada_next;
  logic              resp_valid_next;
  logic [DATA_W-1:0] resp_dado_next;
  logic              resp_erro_next;

  logic              desalinhado;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] valor_carga;
  logic [DATA_W-1:0] palavra_mesclada;

  assign req_ready = (state_reg == IDLE);

  // Sizes 10 and 11 are both word accesses, so tam[1] alone marks a word.
  assign desalinhado = ((req_tam == 2'b01) && req_endereco[0]) ||
                       (req_tam[1] && (req_endereco[1:0] != 2'b00));

  assign byte_sel = mem_saida[{lane_reg, 3'b000} +: 8];
  assign half_sel = mem_saida[{lane_reg[1], 4'b0000} +: 16];

  always_comb begin
    valor_carga = mem_saida;
    if (tam_reg == 2'b00)
      valor_carga = {{24{sinal_reg & byte_sel[7]}}, byte_sel};
    else if (tam_reg == 2'b01)
      valor_carga = {{16{sinal_reg & half_sel[15]}}, half_sel};
  end

  // Only the addressed lane is replaced; every other lane keeps what was just read.
  always_comb begin
    palavra_mesclada = mem_saida;
    if (tam_reg == 2'b00)
      palavra_mesclada[{lane_reg, 3'b000} +: 8] = dado_reg[7:0];
    else
      palavra_mesclada[{lane_reg[1], 4'b0000} +: 16] = dado_reg[15:0];
  end

  always_comb begin
    state_next        = state_reg;
    escrita_next      = escrita_reg;
    tam_next          = tam_reg;
    sinal_next        = sinal_reg;
    lane_next         = lane_reg;
    dado_next         = dado_reg;
    mem_rd_wr_next    = 1'b0;
    mem_endereco_next = mem_endereco;
    mem_entrada_next  = mem_entrada;
    resp_valid_next   = 1'b0;
    resp_dado_next    = resp_dado;
    resp_erro_next    = resp_erro;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          escrita_next      = req_escrita;
          tam_next          = req_tam;
          sinal_next        = req_sinal;
          lane_next         = req_endereco[1:0];
          dado_next         = req_dado;
          mem_endereco_next = req_endereco[ADDR_W+1:2];
          if (desalinhado) begin
            state_next      = RESP;
            resp_valid_next = 1'b1;
            resp_dado_next  = '0;
            resp_erro_next  = 1'b1;
          end else if (req_escrita && req_tam[1]) begin
            state_next       = ESCRITA;
            mem_rd_wr_next   = 1'b1;
            mem_entrada_next = req_dado;
          end else begin
            state_next = LE;
          end
        end
      end
      LE: state_next = CAPTURA;
      CAPTURA: begin
        if (escrita_reg) begin
          state_next       = ESCRITA;
          mem_rd_wr_next   = 1'b1;
          mem_entrada_next = palavra_mesclada;
        end else begin
          state_next      = RESP;
          resp_valid_next = 1'b1;
          resp_dado_next  = valor_carga;
          resp_erro_next  = 1'b0;
        end
      end
      ESCRITA: begin
        state_next      = RESP;
        resp_valid_next = 1'b1;
        resp_dado_next  = '0;
        resp_erro_next  = 1'b0;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Asynchronous reset drops an in-flight write strobe before the next edge can commit it.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg    <= IDLE;
      escrita_reg  <= 1'b0;
      tam_reg      <= 2'b00;
      sinal_reg    <= 1'b0;
      lane_reg     <= 2'b00;
      dado_reg     <= '0;
      mem_rd_wr    <= 1'b0;
      mem_endereco <= '0;
      mem_entrada  <= '0;
      resp_valid   <= 1'b0;
      resp_dado    <= '0;
      resp_erro    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      escrita_reg  <= escrita_next;
      tam_reg      <= tam_next;
      sinal_reg    <= sinal_next;
      lane_reg     <= lane_next;
      dado_reg     <= dado_next;
      mem_rd_wr    <= mem_rd_wr_next;
      mem_endereco <= mem_endereco_next;
      mem_entrada  <= mem_entrada_next;
      resp_valid   <= resp_valid_next;
      resp_dado    <= resp_dado_next;
      resp_erro    <= resp_erro_next;
    end
  end

endmodule
